// File: rtl/vm_param_change.sv
// Parametrised single-item vending controller: coin credit, vend, change and refund.
// Optional feature macro: SALES_CNT_EN builds the wrapping vend counter on `sales`.
module vm_param_change #(
  parameter int CREDIT_W   = 4,
  parameter int PRICE      = 3,
  parameter int MAX_CREDIT = 15,
  parameter int CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                cancel,
  output logic                out,
  output logic [1:0]          change,
  output logic                coin_rej,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit,
  output logic [CNT_W-1:0]    sales
);

  // Wide enough that credit + largest coin and PRICE never wrap, even for PRICE > MAX_CREDIT.
  localparam int SUM_W = CREDIT_W + 3;
  localparam logic [SUM_W-1:0] PRICE_S = SUM_W'(PRICE);
  localparam logic [SUM_W-1:0] MAX_S   = SUM_W'(MAX_CREDIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHANGE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                out_q, out_d;
  logic [1:0]          change_q, change_d;
  logic                rej_q, rej_d;
  logic                busy_q, busy_d;

  logic [2:0]          coin_val;
  logic [SUM_W-1:0]    sum;
  logic [CREDIT_W-1:0] rem;

  always_comb begin
    case (coin)
      2'b01:   coin_val = 3'd1;
      2'b10:   coin_val = 3'd2;
      2'b11:   coin_val = 3'd4;
      default: coin_val = 3'd0;
    endcase
  end

  assign sum = SUM_W'(credit_q) + SUM_W'(coin_val);
  assign rem = CREDIT_W'(sum - PRICE_S);

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    out_d    = 1'b0;
    change_d = 2'b00;
    rej_d    = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        if (state_q == COLLECT && cancel) begin
          // Refund reuses the change path; a simultaneous coin goes back to the customer.
          state_d = CHANGE;
          rej_d   = (coin != 2'b00);
        end else if (coin != 2'b00) begin
          if (sum > MAX_S) begin
            rej_d = 1'b1;
          end else if (sum >= PRICE_S) begin
            out_d    = 1'b1;
            credit_d = rem;
            state_d  = (rem != '0) ? CHANGE : IDLE;
          end else begin
            credit_d = sum[CREDIT_W-1:0];
            state_d  = COLLECT;
          end
        end
      end
      CHANGE: begin
        rej_d = (coin != 2'b00);
        if (credit_q >= CREDIT_W'(2)) begin
          change_d = 2'b10;
          credit_d = credit_q - CREDIT_W'(2);
        end else if (credit_q == CREDIT_W'(1)) begin
          change_d = 2'b01;
          credit_d = '0;
        end
        if (credit_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CHANGE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      out_q    <= 1'b0;
      change_q <= 2'b00;
      rej_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      out_q    <= out_d;
      change_q <= change_d;
      rej_q    <= rej_d;
      busy_q   <= busy_d;
    end
  end

`ifdef SALES_CNT_EN
  logic [CNT_W-1:0] sales_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       sales_q <= '0;
    else if (out_d) sales_q <= sales_q + CNT_W'(1);
  end

  assign sales = sales_q;
`else
  assign sales = '0;
`endif

  assign out      = out_q;
  assign change   = change_q;
  assign coin_rej = rej_q;
  assign busy     = busy_q;
  assign credit   = credit_q;

endmodule

// File: tb/tb_vm_param_change.sv
// Directed bench for vm_param_change: default build plus a PRICE=16 instance for rejection at the ceiling.
module tb_vm_param_change;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] coin = 2'b00;
  logic       cancel = 1'b0;
  logic       out;
  logic [1:0] change;
  logic       coin_rej;
  logic       busy;
  logic [3:0] credit;
  logic [7:0] sales;

  logic [1:0] coin16 = 2'b00;
  logic       out16;
  logic [1:0] change16;
  logic       rej16;
  logic       busy16;
  logic [3:0] credit16;
  logic [7:0] sales16;

  int n_checks = 0;
  int n_fail   = 0;
  int n_vend   = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  vm_param_change dut (
    .clk(clk), .rst(rst), .coin(coin), .cancel(cancel), .out(out), .change(change),
    .coin_rej(coin_rej), .busy(busy), .credit(credit), .sales(sales)
  );

  vm_param_change #(.CREDIT_W(4), .PRICE(16), .MAX_CREDIT(15), .CNT_W(8)) dut16 (
    .clk(clk), .rst(rst), .coin(coin16), .cancel(1'b0), .out(out16), .change(change16),
    .coin_rej(rej16), .busy(busy16), .credit(credit16), .sales(sales16)
  );

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; coin = 2'b00; cancel = 1'b0; coin16 = 2'b00;
    tick(); tick();
    n_checks++; if ({out, change, coin_rej, busy} !== 5'b0) begin n_fail++; $display("FAIL reset_ctl: got %b exp 00000", {out, change, coin_rej, busy}); end
    n_checks++; if (credit !== 4'd0) begin n_fail++; $display("FAIL reset_credit: got %0d exp 0", credit); end
    n_checks++; if (sales !== 8'd0) begin n_fail++; $display("FAIL reset_sales: got %0d exp 0", sales); end
    rst = 1'b1;
    n_vend = 0;
    tick();
  endtask

  task automatic test_exact_price();
    coin = 2'b10; tick();
    n_checks++; if (credit !== 4'd2) begin n_fail++; $display("FAIL exact_credit2: got %0d exp 2", credit); end
    n_checks++; if (out !== 1'b0) begin n_fail++; $display("FAIL exact_no_out: got %0d exp 0", out); end
    coin = 2'b01; tick(); n_vend++;
    n_checks++; if (out !== 1'b1) begin n_fail++; $display("FAIL exact_out: got %0d exp 1", out); end
    n_checks++; if (credit !== 4'd0) begin n_fail++; $display("FAIL exact_credit0: got %0d exp 0", credit); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL exact_busy: got %0d exp 0", busy); end
    coin = 2'b00; tick();
    n_checks++; if ({out, change, busy} !== 4'b0) begin n_fail++; $display("FAIL exact_after: got %b exp 0000", {out, change, busy}); end
  endtask

  task automatic test_vend_with_change();
    coin = 2'b11; tick(); n_vend++;
    n_checks++; if (out !== 1'b1) begin n_fail++; $display("FAIL chg_out: got %0d exp 1", out); end
    n_checks++; if (credit !== 4'd1) begin n_fail++; $display("FAIL chg_credit1: got %0d exp 1", credit); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL chg_busy_entry: got %0d exp 1", busy); end
    n_checks++; if (change !== 2'b00) begin n_fail++; $display("FAIL chg_change_early: got %b exp 00", change); end
    coin = 2'b00; tick();
    n_checks++; if (change !== 2'b01) begin n_fail++; $display("FAIL chg_change: got %b exp 01", change); end
    n_checks++; if (out !== 1'b0) begin n_fail++; $display("FAIL chg_out_pulse: got %0d exp 0", out); end
    n_checks++; if (credit !== 4'd0) begin n_fail++; $display("FAIL chg_credit0: got %0d exp 0", credit); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL chg_busy_exit: got %0d exp 0", busy); end
    // Back in IDLE with no gap: a coin on the very next edge is accepted.
    coin = 2'b10; tick();
    n_checks++; if (credit !== 4'd2 || coin_rej !== 1'b0) begin n_fail++; $display("FAIL chg_next_coin: got credit %0d rej %0d exp 2 0", credit, coin_rej); end
    coin = 2'b01; tick(); n_vend++;
    n_checks++; if (out !== 1'b1) begin n_fail++; $display("FAIL chg_next_vend: got %0d exp 1", out); end
    coin = 2'b00; tick();
  endtask

  task automatic test_cancel();
    coin = 2'b01; tick();
    coin = 2'b01; tick();
    n_checks++; if (credit !== 4'd2) begin n_fail++; $display("FAIL cancel_credit2: got %0d exp 2", credit); end
    coin = 2'b00; cancel = 1'b1; tick();
    n_checks++; if (busy !== 1'b1 || credit !== 4'd2 || out !== 1'b0) begin n_fail++; $display("FAIL cancel_entry: got busy %0d credit %0d out %0d exp 1 2 0", busy, credit, out); end
    cancel = 1'b0; tick();
    n_checks++; if (change !== 2'b10) begin n_fail++; $display("FAIL cancel_change: got %b exp 10", change); end
    n_checks++; if (credit !== 4'd0 || busy !== 1'b0 || out !== 1'b0) begin n_fail++; $display("FAIL cancel_done: got credit %0d busy %0d out %0d exp 0 0 0", credit, busy, out); end
    tick();
    n_checks++; if (change !== 2'b00) begin n_fail++; $display("FAIL cancel_one_coin: got %b exp 00", change); end
  endtask

  task automatic test_cancel_idle_and_coin();
    // Cancel in IDLE is ignored; the coin is taken.
    coin = 2'b10; cancel = 1'b1; tick();
    n_checks++; if (credit !== 4'd2 || busy !== 1'b0 || coin_rej !== 1'b0) begin n_fail++; $display("FAIL idle_cancel: got credit %0d busy %0d rej %0d exp 2 0 0", credit, busy, coin_rej); end
    // Cancel in COLLECT with a coin: refund and reject the coin.
    coin = 2'b01; cancel = 1'b1; tick();
    n_checks++; if (coin_rej !== 1'b1 || credit !== 4'd2 || busy !== 1'b1) begin n_fail++; $display("FAIL collect_cancel_coin: got rej %0d credit %0d busy %0d exp 1 2 1", coin_rej, credit, busy); end
    coin = 2'b00; cancel = 1'b0; tick();
    n_checks++; if (change !== 2'b10 || credit !== 4'd0 || coin_rej !== 1'b0) begin n_fail++; $display("FAIL collect_cancel_refund: got chg %b credit %0d rej %0d exp 10 0 0", change, credit, coin_rej); end
    tick();
  endtask

  task automatic test_coin_during_change();
    coin = 2'b10; tick();
    coin = 2'b11; tick(); n_vend++;
    n_checks++; if (out !== 1'b1 || credit !== 4'd3 || busy !== 1'b1) begin n_fail++; $display("FAIL dchg_vend: got out %0d credit %0d busy %0d exp 1 3 1", out, credit, busy); end
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    coin = 2'b11; tick();
    n_checks++; if (coin_rej !== 1'b1) begin n_fail++; $display("FAIL dchg_rej: got %0d exp 1", coin_rej); end
    n_checks++; if (change !== exp_q[0]) begin n_fail++; $display("FAIL dchg_change1: got %b exp %b", change, exp_q[0]); end
    void'(exp_q.pop_front());
    n_checks++; if (credit !== 4'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL dchg_mid: got credit %0d busy %0d exp 1 1", credit, busy); end
    coin = 2'b00; tick();
    n_checks++; if (change !== exp_q[0]) begin n_fail++; $display("FAIL dchg_change2: got %b exp %b", change, exp_q[0]); end
    void'(exp_q.pop_front());
    n_checks++; if (credit !== 4'd0 || busy !== 1'b0 || coin_rej !== 1'b0) begin n_fail++; $display("FAIL dchg_done: got credit %0d busy %0d rej %0d exp 0 0 0", credit, busy, coin_rej); end
    tick();
  endtask

  task automatic test_max_credit_reject();
    coin16 = 2'b11; tick(); tick(); tick();
    coin16 = 2'b10; tick();
    n_checks++; if (credit16 !== 4'd14) begin n_fail++; $display("FAIL max_credit14: got %0d exp 14", credit16); end
    coin16 = 2'b10; tick();
    n_checks++; if (rej16 !== 1'b1 || credit16 !== 4'd14 || out16 !== 1'b0) begin n_fail++; $display("FAIL max_reject: got rej %0d credit %0d out %0d exp 1 14 0", rej16, credit16, out16); end
    coin16 = 2'b01; tick();
    n_checks++; if (rej16 !== 1'b0 || credit16 !== 4'd15) begin n_fail++; $display("FAIL max_fill: got rej %0d credit %0d exp 0 15", rej16, credit16); end
    coin16 = 2'b01; tick();
    n_checks++; if (rej16 !== 1'b1 || credit16 !== 4'd15) begin n_fail++; $display("FAIL max_full_rej: got rej %0d credit %0d exp 1 15", rej16, credit16); end
    coin16 = 2'b00; tick();
    n_checks++; if (rej16 !== 1'b0) begin n_fail++; $display("FAIL max_rej_pulse: got %0d exp 0", rej16); end
  endtask

  task automatic test_sales();
    logic [7:0] exp_sales;
`ifdef SALES_CNT_EN
    exp_sales = 8'(n_vend);
`else
    exp_sales = 8'd0;
`endif
    n_checks++; if (sales !== exp_sales) begin n_fail++; $display("FAIL sales: got %0d exp %0d", sales, exp_sales); end
  endtask

  task automatic test_async_reset_mid_change();
    coin = 2'b10; tick();
    coin = 2'b11; tick();
    coin = 2'b00;
    n_checks++; if (busy !== 1'b1 || credit !== 4'd3) begin n_fail++; $display("FAIL arst_setup: got busy %0d credit %0d exp 1 3", busy, credit); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if ({out, change, coin_rej, busy} !== 5'b0 || credit !== 4'd0 || sales !== 8'd0) begin n_fail++; $display("FAIL arst_outputs: got %b credit %0d sales %0d exp 00000 0 0", {out, change, coin_rej, busy}, credit, sales); end
    tick();
    rst = 1'b1;
    tick();
    n_checks++; if (change !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL arst_idle: got chg %b busy %0d exp 00 0", change, busy); end
  endtask

  initial begin
    test_reset();
    test_exact_price();
    test_vend_with_change();
    test_cancel();
    test_cancel_idle_and_coin();
    test_coin_during_change();
    test_max_credit_reject();
    test_sales();
    test_async_reset_mid_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
